// File: rtl/line_fetch_arbiter_pkg.sv
// Shared types and default widths for the L1-to-L2 line fetch arbiter.
// The caches import the same widths, so both sides agree on line geometry.
package arbiter_types;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} arb_state_t;
  typedef enum logic {SRC_I, SRC_D} arb_src_t;

endpackage

// File: rtl/line_fetch_arbiter_rr_grant_select.sv
// Combinational 2-way round-robin picker. On a tie it favours the side
// that was not granted last, so neither requester can starve.
module rr_grant_select
  import arbiter_types::*;
(
  input  logic     i_req_i,
  input  logic     d_req_i,
  input  arb_src_t last_grant_i,
  output logic     grant_valid_o,
  output arb_src_t grant_src_o
);

  always_comb begin
    grant_valid_o = i_req_i | d_req_i;
    grant_src_o   = SRC_I;
    if (i_req_i && d_req_i) begin
      grant_src_o = (last_grant_i == SRC_I) ? SRC_D : SRC_I;
    end else if (d_req_i) begin
      grant_src_o = SRC_D;
    end
  end

endmodule

// File: rtl/line_fetch_arbiter.sv
// Multiplexes L1 I-cache and D-cache line traffic onto the single L2 port,
// one transaction at a time, with a one-cycle RELEASE gap between grants.
module line_fetch_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_WIDTH  = LINE_W,
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int OFFSET_BITS = $clog2(LINE_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

  arb_state_t            state_q;
  arb_src_t              last_grant_q;
  logic                  l2_read_q;
  logic                  l2_write_q;
  logic [ADDR_WIDTH-1:0] l2_address_q;
  logic [LINE_WIDTH-1:0] l2_wdata_q;
  logic [LINE_WIDTH-1:0] i_rdata_q;
  logic [LINE_WIDTH-1:0] d_rdata_q;

  logic                  d_req_d;
  logic                  grant_valid_d;
  arb_src_t              grant_src_d;
  logic [ADDR_WIDTH-1:0] i_line_addr_d;
  logic [ADDR_WIDTH-1:0] d_line_addr_d;

  assign d_req_d       = d_read | d_write;
  assign i_line_addr_d = i_address & ALIGN_MASK;
  assign d_line_addr_d = d_address & ALIGN_MASK;

  rr_grant_select u_rr_grant_select (
    .i_req_i       (i_read),
    .d_req_i       (d_req_d),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid_d),
    .grant_src_o   (grant_src_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_I;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_address_q <= '0;
      l2_wdata_q   <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_valid_d) begin
            last_grant_q <= grant_src_d;
            if (grant_src_d == SRC_D) begin
              state_q      <= SERVE_D;
              l2_read_q    <= ~d_write;
              l2_write_q   <= d_write;
              l2_address_q <= d_line_addr_d;
              l2_wdata_q   <= d_wdata;
            end else begin
              state_q      <= SERVE_I;
              l2_read_q    <= 1'b1;
              l2_write_q   <= 1'b0;
              l2_address_q <= i_line_addr_d;
            end
          end
        end
        SERVE_I: begin
          if (l2_resp) begin
            state_q    <= RELEASE;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            i_rdata_q  <= l2_rdata;
          end
        end
        SERVE_D: begin
          if (l2_resp) begin
            state_q    <= RELEASE;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            d_rdata_q  <= l2_rdata;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Responses are combinational so the cache sees completion in the resp cycle.
  assign i_resp     = ~rst & l2_resp & (state_q == SERVE_I);
  assign d_resp     = ~rst & l2_resp & (state_q == SERVE_D);
  assign i_rdata    = i_resp ? l2_rdata : i_rdata_q;
  assign d_rdata    = d_resp ? l2_rdata : d_rdata_q;
  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = l2_address_q;
  assign l2_wdata   = l2_wdata_q;

endmodule

// File: tb/tb_line_fetch_arbiter.sv
// Directed self-checking bench for line_fetch_arbiter: one task per scenario,
// expected values written out by hand from the arbiter's behaviour.
module tb_line_fetch_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;

  int vectors;
  int miscompares;

  logic [LW-1:0] dataA;
  logic [LW-1:0] dataB;
  logic [LW-1:0] dataC;
  logic [LW-1:0] dataW;

  line_fetch_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_rdata   (l2_rdata),
    .l2_resp    (l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
    tick();
    tick();
    vectors++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_l2_req: got rd=%b wr=%b expected rd=0 wr=0", l2_read, l2_write);
    end
    vectors++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_resp: got i=%b d=%b expected i=0 d=0", i_resp, d_resp);
    end
    vectors++;
    if (l2_address !== '0 || l2_wdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr_wdata: got addr=%h wdata=%h expected 0", l2_address, l2_wdata);
    end
    vectors++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_rdata: got i=%h d=%h expected 0", i_rdata, d_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_i_only();
    i_read = 1'b1;
    i_address = 32'h0000_1234;
    #1;
    vectors++;
    if (l2_read !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL i_only_no_early_req: got %b expected 0", l2_read);
    end
    tick();
    i_read = 1'b0;
    vectors++;
    if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_address !== 32'h0000_1220) begin
      miscompares++;
      $display("[TB] FAIL i_only_grant: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=00001220",
               l2_read, l2_write, l2_address);
    end
    tick();
    tick();
    vectors++;
    if (l2_read !== 1'b1 || l2_address !== 32'h0000_1220 || i_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL i_only_hold: got rd=%b addr=%h resp=%b expected rd=1 addr=00001220 resp=0",
               l2_read, l2_address, i_resp);
    end
    l2_resp = 1'b1;
    l2_rdata = dataA;
    #1;
    vectors++;
    if (i_resp !== 1'b1 || i_rdata !== dataA) begin
      miscompares++;
      $display("[TB] FAIL i_only_resp: got resp=%b rdata=%h expected resp=1 rdata=%h", i_resp, i_rdata, dataA);
    end
    vectors++;
    if (d_resp !== 1'b0 || d_rdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL i_only_d_quiet: got resp=%b rdata=%h expected resp=0 rdata=0", d_resp, d_rdata);
    end
    tick();
    l2_resp = 1'b0;
    l2_rdata = dataC;
    #1;
    vectors++;
    if (l2_read !== 1'b0 || i_resp !== 1'b0 || i_rdata !== dataA) begin
      miscompares++;
      $display("[TB] FAIL i_only_release: got rd=%b resp=%b rdata=%h expected rd=0 resp=0 rdata=%h",
               l2_read, i_resp, i_rdata, dataA);
    end
    tick();
  endtask

  task automatic test_d_writeback();
    d_write = 1'b1;
    d_address = 32'h8000_0040;
    d_wdata = dataB;
    tick();
    d_write = 1'b0;
    d_wdata = dataC;
    vectors++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_wdata !== dataB || l2_address !== 32'h8000_0040) begin
      miscompares++;
      $display("[TB] FAIL dwb_grant: got wr=%b rd=%b addr=%h wdata=%h expected wr=1 rd=0 addr=80000040 wdata=%h",
               l2_write, l2_read, l2_address, l2_wdata, dataB);
    end
    tick();
    vectors++;
    if (l2_write !== 1'b1 || l2_wdata !== dataB || d_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dwb_hold: got wr=%b wdata=%h resp=%b expected wr=1 wdata=%h resp=0",
               l2_write, l2_wdata, d_resp, dataB);
    end
    l2_resp = 1'b1;
    l2_rdata = dataC;
    #1;
    vectors++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || i_rdata !== dataA) begin
      miscompares++;
      $display("[TB] FAIL dwb_resp: got d=%b i=%b i_rdata=%h expected d=1 i=0 i_rdata=%h",
               d_resp, i_resp, i_rdata, dataA);
    end
    tick();
    l2_resp = 1'b0;
    #1;
    vectors++;
    if (l2_write !== 1'b0 || l2_read !== 1'b0 || d_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dwb_release: got wr=%b rd=%b resp=%b expected all 0", l2_write, l2_read, d_resp);
    end
    tick();
  endtask

  task automatic test_tie_alternation();
    logic expect_d;
    i_read = 1'b1;
    d_read = 1'b1;
    i_address = 32'h0000_0100;
    d_address = 32'h0000_0200;
    expect_d = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      vectors++;
      if (l2_read !== 1'b1 || l2_address !== (expect_d ? 32'h0000_0200 : 32'h0000_0100)) begin
        miscompares++;
        $display("[TB] FAIL tie_grant_%0d: got rd=%b addr=%h expected rd=1 addr=%h", n, l2_read, l2_address,
                 expect_d ? 32'h0000_0200 : 32'h0000_0100);
      end
      tick();
      l2_resp = 1'b1;
      l2_rdata = {8{32'h7700_0000 + 32'(n)}};
      #1;
      vectors++;
      if (d_resp !== expect_d || i_resp !== ~expect_d) begin
        miscompares++;
        $display("[TB] FAIL tie_resp_%0d: got d=%b i=%b expected d=%b i=%b", n, d_resp, i_resp, expect_d, ~expect_d);
      end
      tick();
      l2_resp = 1'b0;
      #1;
      vectors++;
      if (l2_read !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL tie_release_%0d: got %b expected 0", n, l2_read);
      end
      tick();
      expect_d = ~expect_d;
    end
    i_read = 1'b0;
    d_read = 1'b0;
    vectors++;
    if (d_rdata !== {8{32'h7700_0002}} || i_rdata !== {8{32'h7700_0003}}) begin
      miscompares++;
      $display("[TB] FAIL tie_rdata: got d=%h i=%h expected d=%h i=%h", d_rdata, i_rdata,
               {8{32'h7700_0002}}, {8{32'h7700_0003}});
    end
  endtask

  task automatic test_drop_early();
    d_read = 1'b1;
    d_address = 32'h3000_0010;
    tick();
    vectors++;
    if (l2_read !== 1'b1 || l2_address !== 32'h3000_0000) begin
      miscompares++;
      $display("[TB] FAIL drop_grant: got rd=%b addr=%h expected rd=1 addr=30000000", l2_read, l2_address);
    end
    tick();
    d_read = 1'b0;
    d_address = 32'h5555_5555;
    i_read = 1'b1;
    tick();
    vectors++;
    if (l2_read !== 1'b1 || l2_address !== 32'h3000_0000) begin
      miscompares++;
      $display("[TB] FAIL drop_hold: got rd=%b addr=%h expected rd=1 addr=30000000", l2_read, l2_address);
    end
    i_read = 1'b0;
    l2_resp = 1'b1;
    l2_rdata = dataB;
    #1;
    vectors++;
    if (d_resp !== 1'b1 || d_rdata !== dataB || i_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drop_resp: got d=%b rdata=%h i=%b expected d=1 rdata=%h i=0", d_resp, d_rdata, i_resp, dataB);
    end
    tick();
    l2_resp = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_serve();
    i_read = 1'b1;
    i_address = 32'h0000_0040;
    tick();
    i_read = 1'b0;
    vectors++;
    if (l2_read !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rmid_grant: got %b expected 1", l2_read);
    end
    tick();
    tick();
    rst = 1'b1;
    l2_resp = 1'b1;
    l2_rdata = dataC;
    #1;
    vectors++;
    if (i_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rmid_no_resp: got %b expected 0", i_resp);
    end
    tick();
    rst = 1'b0;
    l2_resp = 1'b0;
    #1;
    vectors++;
    if (l2_read !== 1'b0 || l2_address !== '0 || i_rdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL rmid_abandon: got rd=%b addr=%h i_rdata=%h expected rd=0 addr=0 i_rdata=0",
               l2_read, l2_address, i_rdata);
    end
    i_read = 1'b1;
    d_read = 1'b1;
    i_address = 32'h0000_0100;
    d_address = 32'h0000_0200;
    tick();
    i_read = 1'b0;
    d_read = 1'b0;
    vectors++;
    if (l2_read !== 1'b1 || l2_address !== 32'h0000_0200) begin
      miscompares++;
      $display("[TB] FAIL rmid_next_tie: got rd=%b addr=%h expected rd=1 addr=00000200", l2_read, l2_address);
    end
    l2_resp = 1'b1;
    tick();
    l2_resp = 1'b0;
    tick();
  endtask

  task automatic test_stray_and_combined();
    l2_resp = 1'b1;
    l2_rdata = dataA;
    #1;
    vectors++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stray_resp: got i=%b d=%b expected i=0 d=0", i_resp, d_resp);
    end
    tick();
    l2_resp = 1'b0;
    vectors++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stray_no_req: got rd=%b wr=%b expected 0 0", l2_read, l2_write);
    end
    d_read = 1'b1;
    d_write = 1'b1;
    d_address = 32'h0000_ABFF;
    d_wdata = dataW;
    tick();
    d_read = 1'b0;
    d_write = 1'b0;
    vectors++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_address !== 32'h0000_ABE0 || l2_wdata !== dataW) begin
      miscompares++;
      $display("[TB] FAIL combined_write: got wr=%b rd=%b addr=%h wdata=%h expected wr=1 rd=0 addr=0000abe0 wdata=%h",
               l2_write, l2_read, l2_address, l2_wdata, dataW);
    end
    l2_resp = 1'b1;
    #1;
    vectors++;
    if (d_resp !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL combined_resp: got %b expected 1", d_resp);
    end
    tick();
    l2_resp = 1'b0;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    dataA = {8{32'hAAAA_0001}};
    dataB = {8{32'hBBBB_0002}};
    dataC = {8{32'hCCCC_0003}};
    dataW = {8{32'h1234_5678}};
    rst = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    l2_rdata = '0; l2_resp = 1'b0;
    test_reset();
    test_i_only();
    test_d_writeback();
    test_reset();
    test_tie_alternation();
    test_drop_early();
    test_reset_mid_serve();
    test_stray_and_combined();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
